// File: rtl/pwm_led_ctrl.sv
// Memory-mapped N-channel PWM driver with a shared prescaled counter and double-buffered duties.
// Optional per-channel duty fading is enabled by defining PWM_LED_FADE_EN.
module pwm_led_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int PWM_WIDTH   = 8,
    parameter int PRESC_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [NUM_CH-1:0]     pwm_n
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam logic [WA-1:0] W_CTRL  = WA'(0);
    localparam logic [WA-1:0] W_PRESC = WA'(1);
    localparam logic [WA-1:0] W_STAT  = WA'(2);
    localparam logic [WA-1:0] W_DUTY  = WA'(4);
    localparam logic [WA-1:0] W_FADE  = WA'(16);

    logic [WA-1:0] word;
    logic          wr_en;
    logic          rd_en;
    logic          unused_bits;

    assign word        = addr[ADDR_WIDTH-1:2];
    assign wr_en       = cs && we;
    assign rd_en       = cs && !we;
    assign unused_bits = ^{addr[1:0], wdata[31:PRESC_WIDTH]};

    logic                   en_q, en_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pc_q, pc_d;
    logic [PWM_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   tick;
    logic                   period_end;
    logic                   en_rise;
    logic [NUM_CH-1:0]      pwm_n_q, pwm_n_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            rd_val;
    logic [PWM_WIDTH-1:0]   duty_rd [NUM_CH];
`ifdef PWM_LED_FADE_EN
    logic [PRESC_WIDTH-1:0] fade_rd [NUM_CH];
`endif

    always_comb begin
        en_d = en_q;
        if (wr_en && word == W_CTRL) en_d = wdata[0];
        presc_d = presc_q;
        if (wr_en && word == W_PRESC) presc_d = wdata[PRESC_WIDTH-1:0];

        tick       = en_q && (pc_q == presc_q);
        period_end = tick && (cnt_q == {PWM_WIDTH{1'b1}});
        en_rise    = en_d && !en_q;

        // Counters are held at zero while disabled or being disabled, so STAT reads 0 at once
        if (!en_q || !en_d) begin
            pc_d  = '0;
            cnt_d = '0;
        end else begin
            pc_d  = tick ? '0 : pc_q + PRESC_WIDTH'(1);
            cnt_d = tick ? cnt_q + PWM_WIDTH'(1) : cnt_q;
        end
        if (wr_en && word == W_PRESC) pc_d = '0;
    end

    always_comb begin
        rd_val = '0;
        if (word == W_CTRL)       rd_val[0] = en_q;
        else if (word == W_PRESC) rd_val[PRESC_WIDTH-1:0] = presc_q;
        else if (word == W_STAT)  rd_val[PWM_WIDTH-1:0] = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (word == W_DUTY + WA'(c)) rd_val[PWM_WIDTH-1:0] = duty_rd[c];
`ifdef PWM_LED_FADE_EN
            if (word == W_FADE + WA'(c)) rd_val[PRESC_WIDTH-1:0] = fade_rd[c];
`endif
        end
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            presc_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            pwm_n_q <= '1;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            pwm_n_q <= pwm_n_d;
            rdata_q <= rdata_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PWM_WIDTH-1:0] duty_q, duty_d;
            logic [PWM_WIDTH-1:0] act_q, act_d;
            logic                 duty_wr;

            assign duty_wr     = wr_en && (word == W_DUTY + WA'(gi));
            assign duty_rd[gi] = duty_q;
            // All-ones duty is forced fully on rather than (2**W-1)/2**W
            assign pwm_n_d[gi] = ~(en_q && (act_q == {PWM_WIDTH{1'b1}} || cnt_q < act_q));

`ifdef PWM_LED_FADE_EN
            logic [PRESC_WIDTH-1:0] fade_q, fade_d;
            logic [PRESC_WIDTH-1:0] fcnt_q, fcnt_d;
            logic                   fade_wr;

            assign fade_wr     = wr_en && (word == W_FADE + WA'(gi));
            assign fade_rd[gi] = fade_q;

            always_comb begin
                duty_d = duty_wr ? wdata[PWM_WIDTH-1:0] : duty_q;
                fade_d = fade_wr ? wdata[PRESC_WIDTH-1:0] : fade_q;
                act_d  = act_q;
                fcnt_d = fcnt_q;
                if (fade_q == '0) begin
                    if (en_rise || period_end) act_d = duty_q;
                end else if (period_end) begin
                    if (fcnt_q >= fade_q - PRESC_WIDTH'(1)) begin
                        fcnt_d = '0;
                        if (act_q < duty_q)      act_d = act_q + PWM_WIDTH'(1);
                        else if (act_q > duty_q) act_d = act_q - PWM_WIDTH'(1);
                    end else begin
                        fcnt_d = fcnt_q + PRESC_WIDTH'(1);
                    end
                end
                if (fade_wr) fcnt_d = '0;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    duty_q <= '0;
                    act_q  <= '0;
                    fade_q <= '0;
                    fcnt_q <= '0;
                end else begin
                    duty_q <= duty_d;
                    act_q  <= act_d;
                    fade_q <= fade_d;
                    fcnt_q <= fcnt_d;
                end
            end
`else
            // act samples duty_q before this edge's write, so a write on the wrap edge waits a period
            always_comb begin
                duty_d = duty_wr ? wdata[PWM_WIDTH-1:0] : duty_q;
                act_d  = (en_rise || period_end) ? duty_q : act_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    duty_q <= '0;
                    act_q  <= '0;
                end else begin
                    duty_q <= duty_d;
                    act_q  <= act_d;
                end
            end
`endif
        end
    endgenerate

    assign rdata = rdata_q;
    assign pwm_n = pwm_n_q;

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Randomized bench for pwm_led_ctrl; the reference derives counter and active duty from
// elapsed cycles since enable, the prescale value and the duty written before each period start.
module tb_pwm_led_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  pwm_n;

    pwm_led_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .pwm_n (pwm_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: s_m = cycles elapsed since the enabling edge
    bit          en_m;
    int          p_m;
    int          s_m;
    int          duty_m [4];
    int          act_m  [4];
    int          fade_m [4];
    logic [31:0] rd_m;

    function automatic int cnt_m();
        return en_m ? (s_m / (p_m + 1)) % 256 : 0;
    endfunction

    function automatic logic [3:0] exp_pwm();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = !(en_m && (act_m[i] == 255 || cnt_m() < act_m[i]));
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int idx = int'(a[7:2]);
        if (idx == 0) return {31'b0, en_m};
        if (idx == 1) return 32'(p_m);
        if (idx == 2) return 32'(cnt_m());
        if (idx >= 4 && idx < 8) return 32'(duty_m[idx-4]);
`ifdef PWM_LED_FADE_EN
        if (idx >= 16 && idx < 20) return 32'(fade_m[idx-16]);
`endif
        return 32'd0;
    endfunction

    task automatic cycle(input bit c, input bit w, input logic [7:0] a, input logic [31:0] d,
                         input bit chk);
        logic [3:0] ep;
        int idx;
        ep = exp_pwm();
        if (c && !w) rd_m = exp_read(a);
        cs = c; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
        if (chk) check("pwm_n", {28'b0, pwm_n}, {28'b0, ep});
        check("rdata", rdata, rd_m);
        if (en_m) begin
            s_m++;
            if (s_m % (256 * (p_m + 1)) == 0)
                for (int i = 0; i < 4; i++) act_m[i] = duty_m[i];
        end
        if (c && w) begin
            idx = int'(a[7:2]);
            if (idx == 0) begin
                if (!en_m && d[0]) for (int i = 0; i < 4; i++) act_m[i] = duty_m[i];
                if (d[0] != en_m) s_m = 0;
                en_m = d[0];
            end else if (idx == 1) begin
                p_m = int'(d[15:0]);
            end else if (idx >= 4 && idx < 8) begin
                duty_m[idx-4] = int'(d[7:0]);
`ifdef PWM_LED_FADE_EN
            end else if (idx >= 16 && idx < 20) begin
                fade_m[idx-16] = int'(d[15:0]);
`endif
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d, 1'b1);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b1, 1'b0, a, 32'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 32'd0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_pwm_n", {28'b0, pwm_n}, 32'hF);
        check("rst_rdata", rdata, 32'd0);
        en_m = 1'b0; p_m = 0; s_m = 0; rd_m = '0;
        for (int i = 0; i < 4; i++) begin
            duty_m[i] = 0; act_m[i] = 0; fade_m[i] = 0;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rd_addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C};

    task automatic random_cycle(input int max_ch);
        int r;
        int sel;
        logic [7:0] a;
        logic [31:0] d;
        r = int'($urandom_range(0, 99));
        if (r < 3) begin
            a = 8'h10 + 8'(4 * $urandom_range(0, max_ch));
            sel = int'($urandom_range(0, 3));
            d = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd255 : 32'($urandom_range(0, 255));
            wr(a, d);
        end else if (r < 10) begin
            rd(rd_addrs[$urandom_range(0, 7)]);
        end else begin
            idle(1);
        end
    endtask

    initial begin
        int lows;
        do_reset();
        rd(8'h08);
        rd(8'h00);
        rd(8'h40);

        wr(8'h04, 32'd0);
        wr(8'h10, 32'd64);
        wr(8'h14, 32'd20);
        wr(8'h18, 32'd0);
        wr(8'h1C, 32'd255);
        wr(8'h00, 32'd1);

        // PRESC=0: cnt==s; DUTY_1 written mid-period and again exactly on the wrap edge
        for (int n = 0; n < 1100; n++) begin
            if (s_m == 356)      wr(8'h14, 32'd200);
            else if (s_m == 767) wr(8'h14, 32'd50);
            else                 random_cycle(0);
        end

        wr(8'h00, 32'd0);
        rd(8'h08);
        idle(2);

        wr(8'h00, 32'hFFFF_FFF0);
        rd(8'h00);
        wr(8'h08, 32'h55);
        rd(8'h08);
        wr(8'h20, 32'hFF);
        rd(8'h20);
        rd(8'h0C);
        rd(8'h14);
        wr(8'h04, 32'hABCD_0003);
        rd(8'h07);
        idle(3);

        wr(8'h00, 32'd1);
        for (int n = 0; n < 2100; n++) random_cycle(1);

`ifdef PWM_LED_FADE_EN
        do_reset();
        wr(8'h40, 32'd1);
        rd(8'h40);
        wr(8'h10, 32'd3);
        wr(8'h00, 32'd1);
        for (int k = 0; k < 4; k++) begin
            lows = 0;
            for (int j = 0; j < 256; j++) begin
                cycle(1'b0, 1'b0, 8'h00, 32'd0, 1'b0);
                if (!pwm_n[0]) lows++;
            end
            check("fade_period", 32'(lows), 32'(k));
        end
`else
        wr(8'h40, 32'd5);
        rd(8'h40);
        lows = 0;
`endif

        rd(8'h04);
        do_reset();
        rd(8'h08);
        rd(8'h10);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
